// File: rtl/midi_pkg.sv
// Shared MIDI transmitter definitions: FSM state type, status-byte class
// constants and helpers that classify a status byte and give the number of
// bytes its message occupies on the wire.
package midi_pkg;

  typedef enum logic [1:0] {IDLE, STAT, D1, D2} state_t;

  localparam logic [7:0] NOTE_OFF  = 8'h80;
  localparam logic [7:0] PROG_CHG  = 8'hC0;
  localparam logic [7:0] CHAN_AT   = 8'hD0;
  localparam logic [7:0] SYSEX     = 8'hF0;
  localparam logic [7:0] MTC_QF    = 8'hF1;
  localparam logic [7:0] SONG_POS  = 8'hF2;
  localparam logic [7:0] SONG_SEL  = 8'hF3;
  localparam logic [7:0] SYSEX_END = 8'hF7;
  localparam logic [7:0] RT_MIN    = 8'hF8;

  // Channel voice/mode messages 80..EF
  function automatic logic is_channel(input logic [7:0] status);
    return (status >= NOTE_OFF) && (status < SYSEX);
  endfunction

  // System common F0..F7
  function automatic logic is_system_common(input logic [7:0] status);
    return (status >= SYSEX) && (status <= SYSEX_END);
  endfunction

  // Total bytes in the message including status; 0 for a non-status byte
  function automatic logic [1:0] byte_count(input logic [7:0] status);
    logic [1:0] n;
    n = 2'd0;
    if (!status[7]) begin
      n = 2'd0;
    end else if (is_channel(status)) begin
      if ((status & 8'hF0) == PROG_CHG || (status & 8'hF0) == CHAN_AT) n = 2'd2;
      else n = 2'd3;
    end else if (status == SONG_POS) begin
      n = 2'd3;
    end else if (status == MTC_QF || status == SONG_SEL) begin
      n = 2'd2;
    end else begin
      n = 2'd1;
    end
    return n;
  endfunction

endpackage

// File: rtl/midi_msg_tx_if.sv
// Message handshake bundle for midi_msg_tx.
//   msg_valid  : source offers a message
//   msg_ready  : transmitter can accept this cycle
//   msg_status : status byte
//   msg_data1/2: data bytes (7 bits each, sent with bit7=0)
interface midi_msg_tx_if;
  logic       msg_valid;
  logic       msg_ready;
  logic [7:0] msg_status;
  logic [6:0] msg_data1;
  logic [6:0] msg_data2;

  modport master (output msg_valid, msg_status, msg_data1, msg_data2,
                  input  msg_ready);
  modport slave  (input  msg_valid, msg_status, msg_data1, msg_data2,
                  output msg_ready);
endinterface

// File: rtl/midi_tx_ser.sv
// Single-byte MIDI/UART serializer: start bit, 8 data bits LSB first, stop bit,
// each CLKS_PER_BIT cycles long.
//   clk, rst : clock, synchronous active-high reset
//   start    : load data and begin a frame (line goes low on this edge)
//   data     : byte to send
//   txd      : serial line, idle high
//   done     : high in the last cycle of the stop bit
module midi_tx_ser #(
  parameter int unsigned CLKS_PER_BIT = 1600
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] data,
  output logic       txd,
  output logic       done
);

  localparam logic [11:0] LAST_CYC = 12'(CLKS_PER_BIT - 1);

  logic        active;
  logic [11:0] cyc;
  logic [3:0]  idx;
  logic [8:0]  shreg;

  // Starting a frame takes priority so a new byte can begin in the cycle
  // right after the previous stop bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      active <= 1'b0;
      txd    <= 1'b1;
      cyc    <= '0;
      idx    <= '0;
      shreg  <= '1;
    end else if (start) begin
      active <= 1'b1;
      txd    <= 1'b0;
      cyc    <= '0;
      idx    <= '0;
      shreg  <= {1'b1, data};
    end else if (active) begin
      if (cyc == LAST_CYC) begin
        cyc <= '0;
        if (idx == 4'd9) begin
          active <= 1'b0;
        end else begin
          idx   <= idx + 4'd1;
          txd   <= shreg[0];
          shreg <= {1'b1, shreg[8:1]};
        end
      end else begin
        cyc <= cyc + 12'd1;
      end
    end
  end

  assign done = active && (idx == 4'd9) && (cyc == LAST_CYC);

endmodule

// File: rtl/midi_msg_tx.sv
// MIDI message transmitter with optional running-status compression.
//   reg_clk, reset_reg : clock, synchronous active-high reset
//   msg (slave)        : message handshake (valid/ready, status, data1, data2)
//   running_en         : omit repeated channel status bytes
//   midi_txd           : serial MIDI output, idle high
//   busy               : a message is being sent
//   byte_done          : pulse at the end of each byte's stop bit
module midi_msg_tx
  import midi_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 1600
) (
  input  logic         reg_clk,
  input  logic         reset_reg,
  midi_msg_tx_if.slave msg,
  input  logic         running_en,
  output logic         midi_txd,
  output logic         busy,
  output logic         byte_done
);

  state_t     state_q, state_d;
  logic [7:0] status_q;
  logic [6:0] data1_q, data2_q;
  logic [1:0] count_q;
  logic [7:0] run_q;
  logic       acc_q, launch_q, drop_q;

  logic       accept, omit, ser_start, ser_done;
  logic [7:0] ser_byte;

  assign accept = msg.msg_valid && msg.msg_ready;
  assign omit   = running_en && is_channel(msg.msg_status) && (msg.msg_status == run_q);

  // drop_q holds ready low for the one cycle after a discarded data byte.
  assign msg.msg_ready = (state_q == IDLE) && !reset_reg && !drop_q;
  assign busy          = (state_q != IDLE);
  assign byte_done     = ser_done;

  always_ff @(posedge reg_clk) begin
    if (reset_reg) begin
      state_q  <= IDLE;
      status_q <= '0;
      data1_q  <= '0;
      data2_q  <= '0;
      count_q  <= '0;
      run_q    <= '0;
      acc_q    <= 1'b0;
      launch_q <= 1'b0;
      drop_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= accept && msg.msg_status[7];
      launch_q <= acc_q;
      drop_q   <= accept && !msg.msg_status[7];
      if (accept && msg.msg_status[7]) begin
        status_q <= msg.msg_status;
        data1_q  <= msg.msg_data1;
        data2_q  <= msg.msg_data2;
        count_q  <= byte_count(msg.msg_status);
      end
      if (!running_en) begin
        run_q <= '0;
      end else if (accept) begin
        if (is_channel(msg.msg_status)) run_q <= msg.msg_status;
        else if (is_system_common(msg.msg_status)) run_q <= '0;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept && msg.msg_status[7]) state_d = omit ? D1 : STAT;
      STAT: if (ser_done) state_d = (count_q == 2'd1) ? IDLE : D1;
      D1:   if (ser_done) state_d = (count_q == 2'd3) ? D2 : IDLE;
      D2:   if (ser_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // The serializer loads on the edge where the FSM moves, so the byte is
  // selected from the state being entered. The first byte is launched two
  // edges after accept via acc_q/launch_q; later bytes chain off ser_done.
  always_comb begin
    ser_byte = '0;
    case (state_d)
      STAT:    ser_byte = status_q;
      D1:      ser_byte = {1'b0, data1_q};
      D2:      ser_byte = {1'b0, data2_q};
      default: ser_byte = '0;
    endcase
  end

  assign ser_start = launch_q || (ser_done && state_d != IDLE);

  midi_tx_ser #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_ser (
    .clk   (reg_clk),
    .rst   (reset_reg),
    .start (ser_start),
    .data  (ser_byte),
    .txd   (midi_txd),
    .done  (ser_done)
  );

endmodule

// File: tb/tb_midi_msg_tx.sv
module tb_midi_msg_tx;

  localparam int CPB   = 4;
  localparam int FRAME = 10 * CPB;

  logic reg_clk = 1'b0;
  logic reset_reg, running_en, midi_txd, busy, byte_done;

  midi_msg_tx_if bus();

  midi_msg_tx #(.CLKS_PER_BIT(CPB)) dut (
    .reg_clk    (reg_clk),
    .reset_reg  (reset_reg),
    .msg        (bus.slave),
    .running_en (running_en),
    .midi_txd   (midi_txd),
    .busy       (busy),
    .byte_done  (byte_done)
  );

  always #5 reg_clk = ~reg_clk;

  int checks = 0;
  int errors = 0;
  int rs_model = -1;
  int exp_q[$];

  function automatic int n_bytes(input int st);
    if (st < 128) return 0;
    if (st < 240) return (st / 16 == 12 || st / 16 == 13) ? 2 : 3;
    if (st == 242) return 3;
    if (st == 241 || st == 243) return 2;
    return 1;
  endfunction

  // Reference: list of bytes the message should put on the wire
  task automatic model_msg(input int st, input int d1, input int d2, input int run);
    int n;
    bit chan, omit;
    exp_q.delete();
    if (run == 0) rs_model = -1;
    if (st < 128) return;
    n = n_bytes(st);
    chan = (st >= 128 && st < 240);
    omit = (run != 0) && chan && (st == rs_model);
    if (!omit) exp_q.push_back(st);
    if (n >= 2) exp_q.push_back(d1);
    if (n == 3) exp_q.push_back(d2);
    if (chan) rs_model = (run != 0) ? st : -1;
    else if (st < 248) rs_model = -1;
  endtask

  task automatic scramble();
    bus.msg_valid  = 1'($urandom_range(0, 1));
    bus.msg_status = 8'($urandom);
    bus.msg_data1  = 7'($urandom);
    bus.msg_data2  = 7'($urandom);
  endtask

  task automatic run_msg(input int st, input int d1, input int d2, input int run,
                         input int abort_at);
    int nb, len, wave_err, done_err, rdy_err, first_bad, hi_cnt;
    int got[3];
    bit aborted;
    @(negedge reg_clk);
    running_en     = run[0];
    bus.msg_valid  = 1'b1;
    bus.msg_status = 8'(st);
    bus.msg_data1  = 7'(d1);
    bus.msg_data2  = 7'(d2);
    for (int i = 0; i < 200 && bus.msg_ready !== 1'b1; i++) @(negedge reg_clk);
    checks++;
    if (bus.msg_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_wait st=%02h got ready=%b want 1", st, bus.msg_ready);
      bus.msg_valid = 1'b0;
      return;
    end
    model_msg(st, d1, d2, run);
    nb  = exp_q.size();
    len = nb * FRAME;
    @(negedge reg_clk);
    scramble();
    checks++;
    if (bus.msg_ready !== 1'b0) begin
      errors++;
      $display("FAIL ready_after_accept st=%02h got %b want 0", st, bus.msg_ready);
    end
    if (nb == 0) begin
      checks++;
      if (busy !== 1'b0) begin
        errors++;
        $display("FAIL discard_busy st=%02h got %b want 0", st, busy);
      end
      @(negedge reg_clk);
      checks++;
      if (bus.msg_ready !== 1'b1) begin
        errors++;
        $display("FAIL discard_ready st=%02h got %b want 1", st, bus.msg_ready);
      end
      bus.msg_valid = 1'b0;
      hi_cnt = 0;
      for (int c = 0; c < 2 * FRAME; c++) begin
        @(negedge reg_clk);
        if (midi_txd === 1'b1 && byte_done === 1'b0) hi_cnt++;
      end
      checks++;
      if (hi_cnt != 2 * FRAME) begin
        errors++;
        $display("FAIL discard_quiet st=%02h got %0d idle cycles want %0d", st, hi_cnt, 2 * FRAME);
      end
      return;
    end
    @(negedge reg_clk);
    scramble();
    checks++;
    if (midi_txd !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL pre_start st=%02h got txd=%b busy=%b want 1 1", st, midi_txd, busy);
    end
    wave_err = 0; done_err = 0; rdy_err = 0; first_bad = -1; aborted = 0;
    got[0] = 0; got[1] = 0; got[2] = 0;
    for (int c = 0; c < len; c++) begin
      int fi, k, b;
      logic ebit;
      @(negedge reg_clk);
      fi = c / FRAME;
      k  = (c % FRAME) / CPB;
      b  = exp_q[fi];
      ebit = (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : 1'((b >> (k - 1)) & 1);
      if (midi_txd !== ebit) begin
        wave_err++;
        if (first_bad < 0) first_bad = c;
      end
      if (byte_done !== ((c % FRAME) == FRAME - 1)) done_err++;
      if (bus.msg_ready !== 1'b0) rdy_err++;
      if (c % CPB == CPB / 2 && k >= 1 && k <= 8 && midi_txd === 1'b1)
        got[fi] = got[fi] | (1 << (k - 1));
      if (c == abort_at) begin
        aborted = 1;
        break;
      end
      scramble();
    end
    checks++;
    if (wave_err != 0) begin
      errors++;
      $display("FAIL waveform st=%02h got %0d bad cycles (first at %0d) want 0", st, wave_err, first_bad);
    end
    checks++;
    if (done_err != 0) begin
      errors++;
      $display("FAIL byte_done st=%02h got %0d bad cycles want 0", st, done_err);
    end
    checks++;
    if (rdy_err != 0) begin
      errors++;
      $display("FAIL ready_low st=%02h got %0d cycles ready high want 0", st, rdy_err);
    end
    if (aborted) begin
      bus.msg_valid = 1'b0;
      reset_reg = 1'b1;
      @(negedge reg_clk);
      checks++;
      if (midi_txd !== 1'b1 || bus.msg_ready !== 1'b0 || busy !== 1'b0 || byte_done !== 1'b0) begin
        errors++;
        $display("FAIL abort_state got txd=%b ready=%b busy=%b done=%b want 1 0 0 0",
                 midi_txd, bus.msg_ready, busy, byte_done);
      end
      reset_reg = 1'b0;
      rs_model = -1;
      #1;
      checks++;
      if (bus.msg_ready !== 1'b1) begin
        errors++;
        $display("FAIL abort_release_ready got %b want 1", bus.msg_ready);
      end
      return;
    end
    for (int i = 0; i < nb; i++) begin
      checks++;
      if (got[i] != exp_q[i]) begin
        errors++;
        $display("FAIL byte%0d st=%02h got %02h want %02h", i, st, got[i], exp_q[i]);
      end
    end
    @(negedge reg_clk);
    bus.msg_valid = 1'b0;
    checks++;
    if (bus.msg_ready !== 1'b1 || busy !== 1'b0 || midi_txd !== 1'b1) begin
      errors++;
      $display("FAIL msg_end st=%02h got ready=%b busy=%b txd=%b want 1 0 1",
               st, bus.msg_ready, busy, midi_txd);
    end
  endtask

  task automatic test_reset();
    reset_reg      = 1'b1;
    running_en     = 1'b0;
    bus.msg_valid  = 1'b0;
    bus.msg_status = '0;
    bus.msg_data1  = '0;
    bus.msg_data2  = '0;
    repeat (3) @(negedge reg_clk);
    checks++;
    if (midi_txd !== 1'b1 || bus.msg_ready !== 1'b0 || busy !== 1'b0 || byte_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_state got txd=%b ready=%b busy=%b done=%b want 1 0 0 0",
               midi_txd, bus.msg_ready, busy, byte_done);
    end
    reset_reg = 1'b0;
    rs_model = -1;
    #1;
    checks++;
    if (bus.msg_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_ready got %b want 1", bus.msg_ready);
    end
  endtask

  task automatic test_basic();
    run_msg(8'h90, 8'h3C, 8'h64, 0, -1);
  endtask

  task automatic test_running();
    run_msg(8'h90, 8'h3C, 8'h64, 1, -1);
    run_msg(8'h90, 8'h40, 8'h7F, 1, -1);
  endtask

  task automatic test_discard();
    run_msg(8'h3C, 8'h11, 8'h22, 0, -1);
  endtask

  task automatic test_realtime();
    run_msg(8'h90, 8'h3C, 8'h64, 1, -1);
    run_msg(8'hF8, 8'h00, 8'h00, 1, -1);
    run_msg(8'h90, 8'h3C, 8'h00, 1, -1);
  endtask

  task automatic test_classes();
    run_msg(8'hC5, 8'h05, 8'h33, 0, -1);
    run_msg(8'h90, 8'h01, 8'h02, 1, -1);
    run_msg(8'hF2, 8'h10, 8'h20, 1, -1);
    run_msg(8'h90, 8'h11, 8'h22, 1, -1);
  endtask

  task automatic test_abort();
    run_msg(8'h90, 8'h3C, 8'h64, 1, FRAME + 5 * CPB + 1);
    run_msg(8'h90, 8'h3C, 8'h66, 1, -1);
  endtask

  task automatic test_random();
    int last_chan = 8'h90;
    for (int n = 0; n < 40; n++) begin
      int st;
      if ($urandom_range(0, 9) < 4) st = last_chan;
      else st = int'($urandom_range(0, 255));
      if (st >= 128 && st < 240) last_chan = st;
      run_msg(st, int'($urandom_range(0, 127)), int'($urandom_range(0, 127)),
              ($urandom_range(0, 3) != 0) ? 1 : 0, -1);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_running();
    test_discard();
    test_realtime();
    test_classes();
    test_abort();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/midi_msg_tx.md
MIDI_MSG_TX -- requirements
Module: midi_msg_tx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 1600, reg_clk cycles per MIDI bit (31250 baud at 50 MHz); legal range 4..4095.
REQ-002 reg_clk  input  1  single clock; all logic on rising edge.
REQ-003 reset_reg  input  1  synchronous, active-high reset.
REQ-004 msg_valid  input  1  message offered.
REQ-005 msg_ready  output  1  block can accept a message this cycle.
REQ-006 msg_status  input  8  MIDI status byte.
REQ-007 msg_data1  input  7  first data byte, sent with bit7=0.
REQ-008 msg_data2  input  7  second data byte, sent with bit7=0.
REQ-009 running_en  input  1  enables running-status compression.
REQ-010 midi_txd  output  1  serial MIDI out, idle high.
REQ-011 busy  output  1  message in progress.
REQ-012 byte_done  output  1  one-cycle pulse at the end of each transmitted byte's stop bit.

Function
REQ-013 Message is accepted on any edge where msg_valid && msg_ready; all three fields are latched there; msg_ready is 0 from the following cycle until the message completes.
REQ-014 msg_ready is 1 only in IDLE with reset_reg low; busy is the inverse of (state==IDLE).
REQ-015 Byte count from status: 8x,9x,Ax,Bx,Ex,F2 -> 3; Cx,Dx,F1,F3 -> 2; F6,F8-FF -> 1; F0,F4,F5,F7 -> 1 (status byte only).
REQ-016 Status with bit7=0 is accepted and discarded: no bytes sent, running status unchanged, msg_ready back to 1 on the next cycle.
REQ-017 Running status register holds the last sent channel status (80-EF); cleared by reset, by any sent F0-F7, and by running_en=0.
REQ-018 F8-FF (realtime) never alter the running status register.
REQ-019 With running_en=1 and a channel status equal to the running status register, the status byte is omitted and only data bytes are sent.
REQ-020 FSM states: IDLE, STAT, D1, D2; IDLE -> STAT (or D1 when status omitted) on accept; each state sends one byte and advances on byte_done; exit to IDLE after the last byte per REQ-015.
REQ-021 Byte frame: start bit 0, 8 data bits LSB first, stop bit 1; each bit exactly CLKS_PER_BIT cycles; frame = 10*CLKS_PER_BIT cycles.
REQ-022 midi_txd falls to the start bit on the second rising edge after the accept edge.
REQ-023 Bytes of one message are back-to-back: next start bit begins on the cycle after byte_done.
REQ-024 byte_done asserts in the last cycle of each stop bit; msg_ready returns to 1 the cycle after the final byte_done.
REQ-025 msg_valid and field changes while busy are ignored.

Reset
REQ-026 On reset_reg high at an edge: state IDLE, midi_txd=1, msg_ready=0, busy=0, byte_done=0, running status cleared, bit/cycle counters 0.
REQ-027 Reset mid-frame aborts immediately (midi_txd high on the next edge); msg_ready=1 on the first cycle after reset_reg drops.

Structure
REQ-028 Shared package midi_pkg holds the FSM state enum, status-class constants (NOTE_OFF=8'h80 ... SYSEX_END=8'hF7, RT_MIN=8'hF8) and the byte-count function.
REQ-029 Bit serializer is sub-module midi_tx_ser (start/byte in, txd/done out, CLKS_PER_BIT parameter); midi_msg_tx instantiates it once.

Verification (CLKS_PER_BIT=4)
REQ-030 90/3C/64, running_en=0 -> bytes 90,3C,64 on midi_txd, 120 cycles start to last stop bit, three byte_done pulses.
REQ-031 running_en=1: 90/3C/64 then 90/40/7F -> second message sends only 40,7F (80 cycles).
REQ-032 running_en=1: 90/3C/64, F8, 90/3C/00 -> F8 sent alone; third message sends only 3C,00.
REQ-033 C5/05 -> C5,05 only; F2/10/20 -> F2,10,20 then 90/.. resends status 90.
REQ-034 Status 3C -> no midi_txd activity, msg_ready low exactly one cycle.
REQ-035 reset_reg pulsed during data bit 4 of byte 2 -> midi_txd=1 next edge, msg_ready=1 after release, next 90 message resends status.
